// File: rtl/multicycle_cpu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multicycle_cpu
//  Purpose  : 16-bit-instruction multicycle CPU, four registers, on-chip dmem.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_cpu #(
    parameter int WIDTH      = 16,
    parameter int DMEM_DEPTH = 256
) (
    input  logic             clock,
    input  logic             resetn,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [15:0]      imem_data,
    output logic [WIDTH-1:0] pc,
    output logic [15:0]      ir,
    output logic [WIDTH-1:0] alu_out,
    output logic             halted
);

    localparam int c_ADDR_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_OR   = 4'h3;
    localparam logic [3:0] c_OP_NOR  = 4'h4;
    localparam logic [3:0] c_OP_NAND = 4'h5;
    localparam logic [3:0] c_OP_SLT  = 4'h6;
    localparam logic [3:0] c_OP_ADDI = 4'h7;
    localparam logic [3:0] c_OP_LW   = 4'h8;
    localparam logic [3:0] c_OP_SW   = 4'h9;
    localparam logic [3:0] c_OP_BEQ  = 4'hA;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [15:0]      r_ir;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_halted;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_regs [0:3];
    logic [WIDTH-1:0] r_dmem [0:DMEM_DEPTH-1];

    logic [3:0]          w_op;
    logic [1:0]          w_rs;
    logic [1:0]          w_rt;
    logic [1:0]          w_rd;
    logic [WIDTH-1:0]    w_imm_sext;
    logic [WIDTH-1:0]    w_br_off;
    logic [WIDTH-1:0]    w_alu;
    logic                w_is_rtype;
    logic                w_is_nop;
    logic                w_taken;
    logic [1:0]          w_wb_dest;
    logic [WIDTH-1:0]    w_wb_val;
    logic [c_ADDR_W-1:0] w_dmem_addr;

    assign w_op        = r_ir[15:12];
    assign w_rs        = r_ir[11:10];
    assign w_rt        = r_ir[9:8];
    assign w_rd        = r_ir[7:6];
    assign w_imm_sext  = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
    assign w_br_off    = {w_imm_sext[WIDTH-2:0], 1'b0};
    assign w_is_rtype  = (w_op <= c_OP_SLT);
    assign w_is_nop    = (w_op >= 4'hC) && (w_op <= 4'hE);
    assign w_taken     = (w_op == c_OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
    assign w_wb_dest   = w_is_rtype ? w_rd : w_rt;
    assign w_wb_val    = (w_op == c_OP_LW) ? r_mdr : r_alu_out;
    // Word address wraps naturally by keeping only the low bits of R[rs]+imm.
    assign w_dmem_addr = r_alu_out[c_ADDR_W-1:0];

    always_comb begin
        w_alu = r_a + w_imm_sext;
        case (w_op)
            c_OP_ADD:  w_alu = r_a + r_b;
            c_OP_SUB:  w_alu = r_a - r_b;
            c_OP_AND:  w_alu = r_a & r_b;
            c_OP_OR:   w_alu = r_a | r_b;
            c_OP_NOR:  w_alu = ~(r_a | r_b);
            c_OP_NAND: w_alu = ~(r_a & r_b);
            // Signed compare rather than the sign of a-b, so overflow cannot flip it.
            c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            default:   w_alu = r_a + w_imm_sext;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_alu_out <= '0;
            r_halted  <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_mdr     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_data;
                        r_pc    <= r_pc + WIDTH'(2);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                    if (w_op == c_OP_HALT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (w_is_nop) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    r_alu_out <= w_alu;
                    if (w_is_rtype || w_op == c_OP_ADDI) begin
                        r_state <= S_WRITEBACK;
                    end else if (w_op == c_OP_LW || w_op == c_OP_SW) begin
                        r_state <= S_MEMORY;
                    end else begin
                        if (w_taken) begin
                            r_pc <= r_pc + w_br_off;
                        end
                        r_state <= S_FETCH;
                    end
                end
                S_MEMORY: begin
                    if (w_op == c_OP_LW) begin
                        r_mdr   <= r_dmem[w_dmem_addr];
                        r_state <= S_WRITEBACK;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    if (w_wb_dest != 2'd0) begin
                        r_regs[w_wb_dest] <= w_wb_val;
                    end
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Data memory is deliberately excluded from reset; stores are suppressed on a reset edge.
    always_ff @(posedge clock) begin
        if (resetn && r_state == S_MEMORY && w_op == c_OP_SW) begin
            r_dmem[w_dmem_addr] <= r_b;
        end
    end

    assign imem_addr = r_pc;
    assign imem_req  = resetn && (r_state == S_FETCH);
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign alu_out   = r_alu_out;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter WIDTH, default 16, datapath, register, PC and ALU width (>=16).
REQ-002 Parameter DMEM_DEPTH, default 256, data-memory words (power of 2, <=2^WIDTH).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 imem_addr  output  WIDTH  byte address of instruction being fetched (equals pc).
REQ-006 imem_req  output  1  fetch request; high only in FETCH while resetn is high.
REQ-007 imem_ready  input  1  instruction memory has imem_data valid this cycle.
REQ-008 imem_data  input  16  instruction word.
REQ-009 pc  output  WIDTH  program counter, byte-addressed, even.
REQ-010 ir  output  16  latched instruction register.
REQ-011 alu_out  output  WIDTH  registered result of the last EXECUTE.
REQ-012 halted  output  1  high once a halt instruction retires.

Function
REQ-013 Encoding: op[15:12]; rs[11:10]; rt[9:8]; rd[7:6]; imm[7:0], sign-extended to WIDTH.
REQ-014 Ops: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 nor, 0101 nand, 0110 slt (rd<=rs op rt); 0111 addi, 1000 lw, 1001 sw, 1010 beq, 1011 bne (I-format, target rt); 1111 halt; 1100-1110 nop.
REQ-015 Four registers r0-r3; r0 reads 0 and ignores writes.
REQ-016 States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-017 FETCH: imem_req high, imem_addr=pc stable; on edge with imem_ready high, ir<=imem_data, pc<=pc+2, go DECODE; else remain in FETCH with no state change.
REQ-018 DECODE: latch A=R[rs], B=R[rt]; halt -> HALT; nop -> FETCH; else EXECUTE.
REQ-019 EXECUTE: alu_out<=result; R-type/addi -> WRITEBACK; lw/sw -> MEMORY; beq/bne -> FETCH.
REQ-020 Arithmetic modulo 2^WIDTH, overflow ignored; slt is a true signed compare (correct when subtraction overflows), result 1 or 0.
REQ-021 lw/sw address = (R[rs]+imm) mod DMEM_DEPTH, word-addressed; sw writes R[rt] in MEMORY -> FETCH; lw reads in MEMORY -> WRITEBACK.
REQ-022 WRITEBACK: R[rd] (R-type) or R[rt] (addi, lw) <= value -> FETCH.
REQ-023 Branch taken (beq: R[rs]==R[rt]; bne: unequal): pc<=pc+(imm<<1), pc already incremented; target wraps modulo 2^WIDTH.
REQ-024 Cycles with imem_ready high at first FETCH cycle: R-type/addi 4, lw 5, sw 4, branch 3, nop 2; each ready-low FETCH cycle adds 1.
REQ-025 HALT: halted=1, no writes, imem_req low, pc frozen until reset.
REQ-026 Register and memory writes occur only in WRITEBACK/MEMORY; ir, A, B stable from DECODE to instruction end.

Reset
REQ-027 Edge with resetn low: state<=FETCH, pc<=0, ir<=0, alu_out<=0, halted<=0, r1-r3<=0; data memory not cleared.
REQ-028 Reset overrides any state, including mid-fetch and HALT; no register or memory write occurs on a reset edge.
REQ-029 imem_req low while resetn low; first fetch (address 0) begins the cycle after resetn rises.

Verification
REQ-030 imem_ready tied high; addi r1,r0,15; addi r2,r0,7; add r3,r1,r2; sub r1,r3,r2; halt -> r3=22, r1=15, halted after 18 cycles, pc=10.
REQ-031 r1=7, r2=15: slt r3,r1,r2 -> 1; slt r3,r2,r1 -> 0; WIDTH=16, r1=0x7FFF, r2=0x8000: slt r3,r2,r1 -> 1; add r3,r1,r1 -> 0xFFFE.
REQ-032 addi r1,r0,5; sw r1,3(r0); lw r2,3(r0) -> r2=5; lw at 3 takes 5 cycles; write to r0 via addi r0 leaves r0=0.
REQ-033 beq r0,r0,-1 at pc=4 -> pc returns to 4 (loop); bne r0,r0,+3 -> pc=pc+2 (not taken), 3 cycles each.
REQ-034 imem_ready low 3 cycles in FETCH -> imem_req and imem_addr held, ir unchanged, instruction completes 3 cycles later.
REQ-035 resetn low for one edge during EXECUTE of add and again while halted -> next cycle pc=0, state FETCH, halted=0, destination register not written.
